// File: rtl/frame_scan_if.sv
// rtl/frame_scan_if.sv - image memory read port and pixel stream bundle for frame_scan_ctrl
//
// Purpose: groups the memory read port and the outgoing pixel stream.
// Signals:
//   mem_addr   image memory read address (controller drives)
//   mem_data   image memory read data, one cycle after mem_addr (memory drives)
//   pix_data   pixel value (controller drives)
//   pix_valid  pixel and sideband valid (controller drives)
//   pix_ready  downstream accepts (sink drives)
//   pix_x/y    pixel column / line
//   pix_sof/eol/eof  first pixel / last column / last pixel of frame
// Modports: master = controller side, slave = memory + pixel sink side.
interface frame_scan_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_x;
    logic [7:0]        pix_y;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output mem_addr,
        input  mem_data,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output pix_x,
        output pix_y,
        output pix_sof,
        output pix_eol,
        output pix_eof
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  pix_x,
        input  pix_y,
        input  pix_sof,
        input  pix_eol,
        input  pix_eof
    );
endinterface

// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - raster scan of an image memory into a pixel stream
//
// Purpose: on start, reads IMG_W*IMG_H pixels from a 1-cycle-latency image
// memory in address order and presents them as a valid/ready pixel stream
// with x/y position and sof/eol/eof markers; done pulses once per frame.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          single-cycle frame request, honoured in IDLE only
//   abort          ends the current frame (flushes buffered and in-flight pixels)
//   busy           high in every state except IDLE
//   done           one-cycle pulse in the DONE state
//   bus            frame_scan_if master: memory read port and pixel stream
// Build option: define SCAN_BACKPRESSURE_EN to honour pix_ready with a
// 2-entry output buffer; otherwise pix_ready is ignored and the output is a
// single pipeline register fed by one read per FETCH cycle.
module frame_scan_ctrl #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 148,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    frame_scan_if.master   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [7:0]        X_LAST    = 8'(IMG_W - 1);
    localparam logic [7:0]        Y_LAST    = 8'(IMG_H - 1);

    // Buffer entry: {data, x, y, sof, eol, eof}
    localparam int EW = DATA_W + 19;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        col;
    logic [7:0]        line;
    logic              rd_pend;     // read issued last cycle, data on mem_data now
    logic [7:0]        rd_x;
    logic [7:0]        rd_y;
    logic [1:0]        count;       // pixels held in the output buffer
    logic [EW-1:0]     head;        // entry currently presented on the stream
    logic [EW-1:0]     new_ent;
    logic              ready_eff;
    logic              pop;
    logic              push;
    logic              issue;
    logic              aborting;
    logic              new_eol;

    assign aborting = abort && (state == S_FETCH || state == S_DRAIN);
    assign push     = rd_pend;
    assign pop      = (count != 2'd0) && ready_eff;

    assign new_eol  = (rd_x == X_LAST);
    assign new_ent  = {bus.mem_data, rd_x, rd_y,
                       (rd_x == 8'd0) && (rd_y == 8'd0),
                       new_eol,
                       new_eol && (rd_y == Y_LAST)};

`ifdef SCAN_BACKPRESSURE_EN
    logic [EW-1:0] skid;
    logic [2:0]    occ;

    assign ready_eff = bus.pix_ready;
    // Occupancy after this cycle's departure: a slot freed by a transfer on
    // this edge may be refilled by the read issued on the same edge, which
    // is what sustains one pixel per cycle with pix_ready high.
    assign occ   = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue = (state == S_FETCH) && !abort && (occ < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else if (aborting) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop) begin
                if (count == 2'd2) begin
                    head <= skid;
                    if (push) skid <= new_ent;
                end else if (push) begin
                    head <= new_ent;
                end
            end else if (push) begin
                if (count == 2'd0) head <= new_ent;
                else               skid <= new_ent;
            end
        end
    end
`else
    logic unused_ready;

    assign unused_ready = bus.pix_ready;
    assign ready_eff    = 1'b1;
    assign issue        = (state == S_FETCH) && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
        end else if (aborting) begin
            count <= 2'd0;
        end else begin
            count <= {1'b0, push};
            if (push) head <= new_ent;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            addr    <= '0;
            col     <= 8'd0;
            line    <= 8'd0;
            rd_pend <= 1'b0;
            rd_x    <= 8'd0;
            rd_y    <= 8'd0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                rd_x <= col;
                rd_y <= line;
                if (col == X_LAST) begin
                    col  <= 8'd0;
                    line <= line + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
                // Hold the address on the final read so it never passes the frame.
                if (addr != LAST_ADDR) addr <= addr + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state <= S_FETCH;
                        addr  <= '0;
                        col   <= 8'd0;
                        line  <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (abort)                          state <= S_DONE;
                    else if (issue && addr == LAST_ADDR) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (abort || (pop && head[0])) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign bus.mem_addr  = addr;
    assign bus.pix_valid = (count != 2'd0);
    assign bus.pix_data  = head[EW-1 -: DATA_W];
    assign bus.pix_x     = head[18:11];
    assign bus.pix_y     = head[10:3];
    assign bus.pix_sof   = head[2];
    assign bus.pix_eol   = head[1];
    assign bus.pix_eof   = head[0];
endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb/tb_frame_scan_ctrl.sv - self-checking bench for frame_scan_ctrl
module tb_frame_scan_ctrl;
    localparam int W    = 160;
    localparam int H    = 148;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic busy;
    logic done;

    frame_scan_if #(.ADDR_W(15), .DATA_W(12)) bus ();

    frame_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(15), .DATA_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mem_fn(input logic [14:0] a);
        return 12'((a * 13 + 7) ^ (a >> 5));
    endfunction

    // One-cycle-latency image memory
    always @(posedge clk) bus.mem_data <= mem_fn(bus.mem_addr);

    function automatic logic [30:0] exp_ent(input int k);
        return {mem_fn(15'(k)), 8'(k % W), 8'(k / W),
                k == 0, (k % W) == W - 1, k == NPIX - 1};
    endfunction

    function automatic logic [30:0] cur_ent();
        return {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol, bus.pix_eof};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic        ready;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_valid;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    // mode 0: pix_ready held high; mode 1: pix_ready toggles 1/0.
    // abort_after > 0 aborts once that many pixels have transferred.
    // restart_at >= 0 pulses start again at that cycle of the frame.
    task automatic run_frame(input int mode, input int abort_after, input int restart_at);
        int idx = 0;
        int eol_cnt = 0;
        int first_valid = -1;
        int cyc = 0;
        bit fin = 0;
        bit aborted = 0;
        bit prev_stall = 0;
        logic r_eff;
        logic [30:0] snap = '0;
        logic [30:0] cur;

        @(negedge clk);
        start = 1'b1;
        bus.pix_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_addr0", {48'd0, busy, bus.mem_addr}, {48'd0, 1'b1, 15'd0});

        while (!fin && !aborted && cyc < 60000) begin
            @(negedge clk);
            bus.pix_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            start = (cyc == restart_at);
            #1;
`ifdef SCAN_BACKPRESSURE_EN
            r_eff = bus.pix_ready;
`else
            r_eff = 1'b1;
`endif
            cur = cur_ent();
            if (prev_stall) check("stall_hold", 64'(cur), 64'(snap));
            if (done) begin
                fin = 1;
                check("valid_in_done", 64'(bus.pix_valid), 64'd0);
            end
            if (bus.pix_valid && first_valid < 0) first_valid = cyc;
            if (bus.pix_valid && r_eff) begin
                check($sformatf("xfer%0d", idx), 64'(cur), 64'(exp_ent(idx)));
                idx++;
                if (bus.pix_eol) eol_cnt++;
            end
            prev_stall = bus.pix_valid && !r_eff;
            snap = cur;
            cyc++;
            if (abort_after > 0 && idx == abort_after && !fin) aborted = 1;
        end
        start = 1'b0;
        check("first_valid_latency", 64'(first_valid), 64'd2);

        if (aborted) begin
            @(negedge clk);
            bus.pix_ready = 1'b1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            check("abort_next", {61'd0, bus.pix_valid, done, busy}, {61'd0, 1'b0, 1'b1, 1'b1});
            @(posedge clk);
            #1;
            check("abort_idle", {61'd0, bus.pix_valid, done, busy}, 64'd0);
        end else begin
            check("frame_timeout", 64'(fin), 64'd1);
            check("frame_count", 64'(idx), 64'(NPIX));
            check("eol_count", 64'(eol_cnt), 64'(H));
            @(posedge clk);
            #1;
            check("after_done", {61'd0, bus.pix_valid, done, busy}, 64'd0);
            @(posedge clk);
            #1;
            check("done_once", {62'd0, done, busy}, 64'd0);
        end
    endtask

    initial begin
        //             start abort ready busy done valid addr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};  // idle
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};  // start+abort: stay idle
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0};  // E0
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd1};  // E1
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd2};  // E2: pixel (0,0)
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 15'd2};  // abort -> DONE
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd2};  // back to IDLE

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.pix_ready = 1'b1;
        #1;
        check("reset_state",
              {30'd0, bus.mem_addr, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_valid,
               bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = vecs[i].start;
            abort = vecs[i].abort;
            bus.pix_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {45'd0, busy, done, bus.pix_valid, bus.mem_addr},
                  {45'd0, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_valid, vecs[i].exp_addr});
            if (i == 5) check("vec5_pixel00", 64'(cur_ent()), 64'(exp_ent(0)));
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;

        run_frame(0, 0, 100);    // full frame, repeated start mid-frame
        run_frame(1, 0, -1);     // full frame, pix_ready toggling
        run_frame(0, 500, -1);   // abort after 500 transfers
        run_frame(0, 20, -1);    // restart from address 0 after abort

        // Reset asserted between clock edges in the middle of a frame
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset",
              {30'd0, bus.mem_addr, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_valid,
               bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, done}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_idle%0d", i),
                  {46'd0, busy, done, bus.pix_valid, bus.mem_addr}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 160, pixels per line.
REQ-002 Parameter IMG_H, default 148, lines per frame.
REQ-003 Parameter ADDR_W, default 15, image memory address width.
REQ-004 Parameter DATA_W, default 12, packed RGB444 pixel width.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle frame request; honoured only in IDLE.
REQ-008 abort  input  1  terminates the current frame.
REQ-009 mem_addr  output  ADDR_W  image memory read address.
REQ-010 mem_data  input  DATA_W  image memory read data, valid exactly 1 cycle after its mem_addr.
REQ-011 pix_data  output  DATA_W  registered pixel.
REQ-012 pix_valid  output  1  pix_data and the sideband outputs are valid.
REQ-013 pix_ready  input  1  downstream accepts; a transfer occurs when pix_valid and pix_ready are both high.
REQ-014 pix_x  output  8  column of pix_data (0..IMG_W-1).
REQ-015 pix_y  output  8  line of pix_data (0..IMG_H-1).
REQ-016 pix_sof / pix_eol / pix_eof  output  1 each  marks pixel (0,0) / last column / last pixel of frame.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 States are IDLE, FETCH, DRAIN and DONE; state encoding is free.
REQ-020 IDLE->FETCH on start; the start edge sets mem_addr to 0 and clears the column and line counters.
REQ-021 In FETCH, an address is issued only while (buffered pixels + reads in flight) < 2; each issue increments mem_addr and advances the column counter, which wraps at IMG_W-1 and increments the line counter.
REQ-022 The 2-entry output buffer captures mem_data one cycle after its issue, so no pixel is ever lost or duplicated under any pix_ready pattern.
REQ-023 Pixels leave the buffer in address order; x/y/sof/eol/eof travel with their pixel.
REQ-024 Issuing address IMG_W*IMG_H-1 causes FETCH->DRAIN.
REQ-025 DRAIN->DONE once the eof pixel has transferred.
REQ-026 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-027 Latency with pix_ready held high: start sampled at edge E0 gives pix_valid with pixel (0,0) after edge E2; throughput is then 1 pixel/cycle.
REQ-028 Total pixels per frame is IMG_W*IMG_H (23680 by default); mem_addr never exceeds IMG_W*IMG_H-1.
REQ-029 A start received while not in IDLE is ignored.
REQ-030 start and abort high together in IDLE: abort wins and the state stays IDLE.
REQ-031 abort in FETCH or DRAIN does the following at the next edge:
- flushes the buffer;
- discards reads in flight;
- deasserts pix_valid;
- enters DONE; done pulses.
REQ-032 pix_valid is never high in IDLE or DONE.
REQ-033 While pix_valid is high and pix_ready is low, pix_data and the sideband outputs hold stable.

Reset
REQ-034 Asserting reset forces the following regardless of clk:
- state to IDLE;
- mem_addr, pix_data, pix_x, pix_y to 0;
- pix_valid, pix_sof, pix_eol, pix_eof, busy, done to 0;
- buffer and in-flight count to empty.
REQ-035 Reset mid-frame abandons the frame; after release, only a new start begins a frame.

Configuration
REQ-036 Macro SCAN_BACKPRESSURE_EN compiles in pix_ready handling as specified in REQ-021, REQ-022 and REQ-033.
REQ-037 Without SCAN_BACKPRESSURE_EN:
- pix_ready is ignored and treated as 1;
- one address is issued per FETCH cycle;
- the buffer reduces to a single pipeline register;
- REQ-027 latency and throughput are unchanged.

Verification
REQ-038 Scenario: reset, then start with pix_ready=1 -> pix_valid after 2 edges; exactly 23680 transfers; mem_data echoed in order; done pulses once; busy falls with done.
REQ-039 Scenario: pix_ready toggles 1/0 every cycle (macro on) -> 23680 transfers, none dropped or duplicated, outputs stable while stalled.
REQ-040 Scenario: sideband check -> pix_sof only at (0,0); pix_eol exactly 148 times at x=159; pix_eof only at (159,147).
REQ-041 Scenario: abort after 500 transfers -> pix_valid=0 next cycle, done pulse, IDLE; a following start restarts at address 0.
REQ-042 Scenario: start repeated mid-frame, and start plus abort in IDLE -> both ignored, no effect on the frame or state.
REQ-043 Scenario: reset asserted mid-frame between clock edges -> all outputs 0 immediately; no done pulse.
